// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO multiply/divide sequencer bundle.
// master = pipeline/EX side, slave = the sequencer.
interface hilo_muldiv_ctrl_if #(parameter int DATA_W = 32);
    logic              op_validE;
    logic [2:0]        opE;
    logic [DATA_W-1:0] srcaE;
    logic [DATA_W-1:0] srcbE;
    logic              mf_reqE;
    logic              cancel;
    logic              busy;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output op_validE, opE, srcaE, srcbE, mf_reqE, cancel,
        input  busy, stall_req, done, hi_o, lo_o
    );
    modport slave (
        input  op_validE, opE, srcaE, srcbE, mf_reqE, cancel,
        output busy, stall_req, done, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: iterative 1-bit/cycle shift-add multiply and restoring divide
// on operand magnitudes, with a final sign-fix cycle and EX stall generation.
module hilo_muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hilo_muldiv_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

    stateT               state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;      // mul: {partial, multiplier}; div: {rem, quo}
    logic [DATA_W-1:0]   operand;  // |multiplicand| or |divisor|
    logic [DATA_W-1:0]   rawA;
    logic [DATA_W-1:0]   hiReg, loReg;
    logic                isDiv, negMain, negRem, divZero;
    logic                busyReg, doneReg;

    logic                isMulDiv, isSigned, opDiv;
    logic [DATA_W-1:0]   absA, absB;
    logic [DATA_W:0]     mulSum;
    logic [DATA_W+1:0]   divTrial;
    logic [2*DATA_W-1:0] mulRes;
    logic [DATA_W-1:0]   fixHi, fixLo;

    assign isMulDiv = (bus.opE == OP_MULT) || (bus.opE == OP_MULTU) ||
                      (bus.opE == OP_DIV)  || (bus.opE == OP_DIVU);
    assign isSigned = (bus.opE == OP_MULT) || (bus.opE == OP_DIV);
    assign opDiv    = (bus.opE == OP_DIV)  || (bus.opE == OP_DIVU);
    assign absA     = (isSigned && bus.srcaE[DATA_W-1]) ? -bus.srcaE : bus.srcaE;
    assign absB     = (isSigned && bus.srcbE[DATA_W-1]) ? -bus.srcbE : bus.srcbE;

    assign mulSum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);
    // Extra top bit makes the borrow unambiguous: {rem,bit} can exceed 2^DATA_W.
    assign divTrial = {1'b0, acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]} - {2'b00, operand};

    always_comb begin
        mulRes = negMain ? -acc : acc;
        fixHi  = mulRes[2*DATA_W-1:DATA_W];
        fixLo  = mulRes[DATA_W-1:0];
        if (isDiv) begin
            if (divZero) begin
                fixHi = rawA;
                fixLo = '1;
            end else begin
                fixHi = negRem  ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
                fixLo = negMain ? -acc[DATA_W-1:0]        : acc[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            rawA    <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            isDiv   <= 1'b0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.op_validE && !bus.cancel) begin
                        if (isMulDiv) begin
                            cnt     <= '0;
                            isDiv   <= opDiv;
                            rawA    <= bus.srcaE;
                            divZero <= (bus.srcbE == '0);
                            negMain <= isSigned && (bus.srcaE[DATA_W-1] ^ bus.srcbE[DATA_W-1]);
                            negRem  <= isSigned && bus.srcaE[DATA_W-1];
                            acc     <= {{DATA_W{1'b0}}, opDiv ? absA : absB};
                            operand <= opDiv ? absB : absA;
                            busyReg <= 1'b1;
                            state   <= opDiv ? DIV : MUL;
                        end else if (bus.opE == OP_MTHI) begin
                            hiReg <= bus.srcaE;
                        end else if (bus.opE == OP_MTLO) begin
                            loReg <= bus.srcaE;
                        end
                    end
                end
                MUL, DIV: begin
                    if (bus.cancel) begin
                        busyReg <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        if (state == MUL)
                            acc <= {mulSum, acc[DATA_W-1:1]};
                        else if (divTrial[DATA_W+1])
                            acc <= {acc[2*DATA_W-2:0], 1'b0};
                        else
                            acc <= {divTrial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (!bus.cancel) begin
                        hiReg   <= fixHi;
                        loReg   <= fixLo;
                        doneReg <= 1'b1;
                    end
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busyReg;
    assign bus.done      = doneReg;
    assign bus.hi_o      = hiReg;
    assign bus.lo_o      = loReg;
    assign bus.stall_req = busyReg & (bus.op_validE | bus.mf_reqE);
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized + directed scoreboard bench for hilo_muldiv_ctrl.
module tb_hilo_muldiv_ctrl;
    localparam int W = 32;
    localparam logic [2:0] MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4,
                           MTHI = 3'd5, MTLO = 3'd6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_ctrl_if #(.DATA_W(W)) bus ();
    hilo_muldiv_ctrl #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           id;
    } expT;
    expT sbQ[$];
    int  nCmp = 0;
    int  nErr = 0;
    int  nId  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: returns {HI, LO}.
    function automatic logic [2*W-1:0] refModel(input logic [2:0] op, input logic [W-1:0] a, b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MULT:  begin q = sa * sb; return q[63:0]; end
            MULTU: return ua * ub;
            DIV: begin
                if (b == 0) return {a, {W{1'b1}}};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (b == 0) return {a, {W{1'b1}}};
                return {ub == 0 ? 32'h0 : 32'(ua % ub), 32'(ua / ub)};
            end
            default: return '0;
        endcase
    endfunction

    task automatic push(input logic [2*W-1:0] e);
        expT x;
        x.hi = e[2*W-1:W];
        x.lo = e[W-1:0];
        x.id = nId++;
        sbQ.push_back(x);
    endtask

    // Monitor: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            expT x;
            if (sbQ.size() == 0) begin
                nCmp++;
                nErr++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                x = sbQ.pop_front();
                check($sformatf("op%0d_hi", x.id), bus.hi_o, x.hi);
                check($sformatf("op%0d_lo", x.id), bus.lo_o, x.lo);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Issue one mul/div in IDLE and measure busy length and done width.
    task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, b, input logic [2*W-1:0] e);
        int n;
        @(negedge clk);
        bus.op_validE = 1'b1; bus.opE = op; bus.srcaE = a; bus.srcbE = b;
        @(negedge clk);
        bus.op_validE = 1'b0;
        push(e);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'(W + 1));
        check("done_high", {31'b0, bus.done}, 32'd1);
        @(negedge clk);
        check("done_low", {31'b0, bus.done}, 32'd0);
    endtask

    function automatic logic [W-1:0] pickVal();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        bus.op_validE = 1'b0; bus.opE = '0; bus.srcaE = '0; bus.srcbE = '0;
        bus.mf_reqE = 1'b0; bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi_o, 32'h0);
        check("rst_lo", bus.lo_o, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        rst_n = 1'b1;

        runOp(MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1);
        runOp(DIVU,  32'd100,      32'd7,        64'h00000002_0000000E);
        runOp(DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
        runOp(DIV,   32'd5,        32'd0,        64'h00000005_FFFFFFFF);
        runOp(DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

        // MF held in EX during a long multiply
        @(negedge clk);
        bus.op_validE = 1'b1; bus.opE = MULTU; bus.srcaE = 32'hFFFFFFFF; bus.srcbE = 32'hFFFFFFFF;
        @(negedge clk);
        bus.op_validE = 1'b0;
        push(64'hFFFFFFFE_00000001);
        @(negedge clk);
        bus.mf_reqE = 1'b1;
        #1;
        n = 0;
        while (bus.stall_req && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mf_stall_cycles", 32'(n), 32'd32);
        check("mf_hi", bus.hi_o, 32'hFFFFFFFE);
        check("mf_lo", bus.lo_o, 32'h00000001);
        bus.mf_reqE = 1'b0;

        // Back-to-back MTHI/MTLO in IDLE
        @(negedge clk);
        bus.op_validE = 1'b1; bus.opE = MTHI; bus.srcaE = 32'h1234;
        #1 check("mthi_stall", {31'b0, bus.stall_req}, 32'h0);
        @(negedge clk);
        bus.opE = MTLO; bus.srcaE = 32'h5678;
        #1 check("mtlo_stall", {31'b0, bus.stall_req}, 32'h0);
        @(negedge clk);
        bus.op_validE = 1'b0;
        check("mt_hi", bus.hi_o, 32'h1234);
        check("mt_lo", bus.lo_o, 32'h5678);

        // Cancel a running divide
        @(negedge clk);
        bus.op_validE = 1'b1; bus.opE = DIV; bus.srcaE = 32'd1000; bus.srcbE = 32'd3;
        @(negedge clk);
        bus.op_validE = 1'b0;
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", {31'b0, bus.busy}, 32'h0);
        repeat (40) @(negedge clk);
        check("cancel_hi", bus.hi_o, 32'h1234);
        check("cancel_lo", bus.lo_o, 32'h5678);

        // Cancel alongside an op in IDLE
        @(negedge clk);
        bus.op_validE = 1'b1; bus.opE = MULT; bus.cancel = 1'b1;
        @(negedge clk);
        bus.op_validE = 1'b0; bus.cancel = 1'b0;
        check("cancel_idle_busy", {31'b0, bus.busy}, 32'h0);

        // MTHI held behind a running multiply
        @(negedge clk);
        bus.op_validE = 1'b1; bus.opE = MULT; bus.srcaE = 32'd7; bus.srcbE = 32'hFFFFFFFE;
        @(negedge clk);
        bus.opE = MTHI; bus.srcaE = 32'hCAFE0000;
        push(64'hFFFFFFFF_FFFFFFF2);
        #1;
        n = 0;
        while (bus.stall_req && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mthi_busy_stall", 32'(n), 32'(W + 1));
        @(negedge clk);
        bus.op_validE = 1'b0;
        check("mthi_after_hi", bus.hi_o, 32'hCAFE0000);
        check("mthi_after_lo", bus.lo_o, 32'hFFFFFFF2);

        // Randomized ops against the reference model
        for (int i = 0; i < 14; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = pickVal();
            rb  = pickVal();
            runOp(rop, ra, rb, refModel(rop, ra, rb));
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.op_validE = 1'b1; bus.opE = MULT; bus.srcaE = 32'd3; bus.srcbE = 32'd4;
        @(negedge clk);
        bus.op_validE = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_hi", bus.hi_o, 32'h0);
        check("rstmid_lo", bus.lo_o, 32'h0);
        check("rstmid_busy", {31'b0, bus.busy}, 32'h0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("sb_empty", 32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
